// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan sequencer with operand/result registers.
// Scans enabled digits with optional blanking gap between slots.
module display_scan_ctrl #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_en,
  input  logic       load,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  output logic [3:0] a_q,
  output logic [3:0] b_q,
  output logic [3:0] sum_q,
  output logic [3:0] diff_q,
  output logic [3:0] anode,
  output logic [1:0] digit_idx,
  output logic       slot_tick
);

  localparam int MAXC =
    (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick_q, tick_d;
  logic [1:0]    nxt_idx, first_idx, j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      diff_q <= '0;
    end else if (load) begin
      a_q    <= a_in;
      b_q    <= b_in;
      sum_q  <= a_in + b_in;
      diff_q <= a_in - b_in;
    end
  end

  // Descending offsets so the nearest enabled digit wins; offset 4 is self.
  always_comb begin
    nxt_idx   = idx_q;
    first_idx = 2'd0;
    j         = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      j = idx_q + 2'(i);
      if (digit_en[j]) nxt_idx = j;
    end
    for (int i = 3; i >= 0; i--) begin
      if (digit_en[i]) first_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|digit_en) begin
          state_d = SHOW;
          idx_d   = first_idx;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
      end
      SHOW: begin
        if (digit_en == 4'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!digit_en[idx_q] ||
                     cnt_q == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
          end else begin
            idx_d  = nxt_idx;
            tick_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLANK: begin
        if (digit_en == 4'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = nxt_idx;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign anode     = (state_q == SHOW) ? ~(4'b0001 << idx_q) : 4'b1111;
  assign digit_idx = idx_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a slot-level model.
// Two instances: with a blanking gap and without.
module tb_display_scan_ctrl;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_en = 4'hf;
  logic       load = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;

  logic [3:0] a_q, b_q, sum_q, diff_q, anode;
  logic [1:0] digit_idx;
  logic       slot_tick;
  logic [3:0] a_q0, b_q0, sum_q0, diff_q0, anode0;
  logic [1:0] digit_idx0;
  logic       slot_tick0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .digit_en(digit_en),
    .load(load), .a_in(a_in), .b_in(b_in),
    .a_q(a_q), .b_q(b_q), .sum_q(sum_q), .diff_q(diff_q),
    .anode(anode), .digit_idx(digit_idx), .slot_tick(slot_tick)
  );

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .digit_en(digit_en),
    .load(load), .a_in(a_in), .b_in(b_in),
    .a_q(a_q0), .b_q(b_q0), .sum_q(sum_q0), .diff_q(diff_q0),
    .anode(anode0), .digit_idx(digit_idx0), .slot_tick(slot_tick0)
  );

  // mode: 0 idle, 1 digit lit, 2 gap; left = cycles remaining
  typedef struct {
    int mode;
    int left;
    int idx;
    bit tick;
  } mdl_t;

  mdl_t m2, m0;
  int ma, mb, ms, md;

  function automatic int after(int idx, logic [3:0] en);
    for (int k = 1; k <= 4; k++)
      if (en[(idx + k) % 4]) return (idx + k) % 4;
    return idx;
  endfunction

  function automatic int lowest(logic [3:0] en);
    for (int k = 0; k < 4; k++)
      if (en[k]) return k;
    return 0;
  endfunction

  function automatic mdl_t start(mdl_t m, int idx);
    mdl_t r = m;
    r.mode = 1;
    r.idx = idx;
    r.left = P;
    r.tick = 1'b1;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [3:0] en, int blank);
    mdl_t r = m;
    r.tick = 1'b0;
    if (en == 4'd0) begin
      r.mode = 0;
      return r;
    end
    case (m.mode)
      0: r = start(m, lowest(en));
      1: begin
        r.left = m.left - 1;
        if (r.left == 0 || !en[m.idx]) begin
          if (blank > 0) begin
            r.mode = 2;
            r.left = blank;
          end else begin
            r = start(m, after(m.idx, en));
          end
        end
      end
      default: begin
        r.left = m.left - 1;
        if (r.left == 0) r = start(m, after(m.idx, en));
      end
    endcase
    return r;
  endfunction

  function automatic int exp_an(mdl_t m);
    return (m.mode == 1) ? (~(1 << m.idx)) & 15 : 15;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2 = '{0, 0, 0, 1'b0};
      m0 = '{0, 0, 0, 1'b0};
      ma = 0; mb = 0; ms = 0; md = 0;
    end else begin
      m2 = step(m2, digit_en, 2);
      m0 = step(m0, digit_en, 0);
      if (load) begin
        ma = a_in;
        mb = b_in;
        ms = (a_in + b_in) % 16;
        md = (a_in - b_in + 16) % 16;
      end
    end
  end

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("anode", anode, exp_an(m2));
    chk("idx", digit_idx, m2.idx);
    chk("tick", slot_tick, m2.tick);
    chk("anode0", anode0, exp_an(m0));
    chk("idx0", digit_idx0, m0.idx);
    chk("tick0", slot_tick0, m0.tick);
    chk("a_q", a_q, ma);
    chk("b_q", b_q, mb);
    chk("sum_q", sum_q, ms);
    chk("diff_q", diff_q, md);
    chk("sum_q0", sum_q0, ms);
    chk("diff_q0", diff_q0, md);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc_rand();
    cyc();
    load = ($urandom % 3 == 0);
    a_in = 4'($urandom);
    b_in = 4'($urandom);
  endtask

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (30) cyc();

    load = 1'b1; a_in = 4'd9; b_in = 4'd12;
    cyc();
    load = 1'b0; a_in = 4'd1; b_in = 4'd1;
    cyc();
    chk("a_9", a_q, 9);
    chk("b_12", b_q, 12);
    chk("sum_21", sum_q, 5);
    chk("diff_m3", diff_q, 13);

    digit_en = 4'b0101;
    repeat (30) cyc_rand();
    digit_en = 4'b0010;
    repeat (20) cyc_rand();
    load = 1'b0;

    digit_en = 4'b1111;
    for (int k = 0; k < 50 && !(m2.mode == 1 && m2.idx == 1); k++)
      cyc();
    chk("reach_d1", int'(m2.mode == 1 && m2.idx == 1), 1);
    digit_en = 4'b1101;
    repeat (12) cyc();
    digit_en = 4'b0000;
    repeat (5) cyc();
    chk("idle_an", anode, 15);

    digit_en = 4'b1111;
    repeat (300) begin
      if ($urandom % 8 == 0) digit_en = 4'($urandom);
      cyc_rand();
    end

    digit_en = 4'b1111;
    load = 1'b1; a_in = 4'd7; b_in = 4'd3;
    cyc();
    load = 1'b0;
    repeat (2) cyc();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all();
    chk("rst_a", a_q, 0);
    chk("rst_an", anode, 15);
    chk("rst_an0", anode0, 15);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
